// File: rtl/waverforms_out_stage.sv
// Output stage after the amplitude multiplier: round/shift/saturate each product to DAC
// width and deliver it on an AXI4-Stream master through a 2-entry skid buffer.
module waverforms_out_stage #(
  parameter int unsigned IN_W      = 30,
  parameter int unsigned OUT_W     = 16,
  parameter int unsigned SHIFT     = 14,
  parameter int unsigned FRAME_LEN = 256
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic [IN_W-1:0]  prod_data,
  input  logic             prod_valid,
  output logic             prod_ready,
  output logic [OUT_W-1:0] m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast,
  output logic             sat_sticky,
  input  logic             sat_clr
);

  localparam int unsigned IDX_W = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  logic [IN_W:0]      rnd_c;
  logic [IN_W:0]      sum;
  logic [IN_W:0]      r;
  logic               sat_now;
  logic [OUT_W-1:0]   smp_data;
  logic               smp_last;

  logic               main_valid_q, main_valid_d;
  logic [OUT_W-1:0]   main_data_q,  main_data_d;
  logic               main_last_q,  main_last_d;
  logic               skid_valid_q, skid_valid_d;
  logic [OUT_W-1:0]   skid_data_q,  skid_data_d;
  logic               skid_last_q,  skid_last_d;
  logic [IDX_W-1:0]   idx_q,        idx_d;
  logic               sat_q,        sat_d;

  logic               in_xfer;
  logic               out_xfer;

  // Rounding constant and sum are one bit wider than the product so the add cannot overflow.
  always_comb begin
    rnd_c            = '0;
    rnd_c[SHIFT-1]   = 1'b1;
    sum              = {1'b0, prod_data} + rnd_c;
    r                = sum >> SHIFT;
    sat_now          = |r[IN_W:OUT_W];
    smp_data         = sat_now ? '1 : r[OUT_W-1:0];
    smp_last         = (idx_q == LAST_IDX);
  end

  assign prod_ready = ~skid_valid_q;
  assign in_xfer    = prod_valid & ~skid_valid_q;
  assign out_xfer   = main_valid_q & m_axis_tready;

  // Skid full blocks input, so only the skid-empty branch ever has to place a new sample.
  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    main_last_d  = main_last_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_last_d  = skid_last_q;
    idx_d        = idx_q;
    sat_d        = sat_q;

    if (skid_valid_q) begin
      if (out_xfer) begin
        main_data_d  = skid_data_q;
        main_last_d  = skid_last_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end
    end else if (!main_valid_q || out_xfer) begin
      if (in_xfer) begin
        main_data_d  = smp_data;
        main_last_d  = smp_last;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (in_xfer) begin
      skid_data_d  = smp_data;
      skid_last_d  = smp_last;
      skid_valid_d = 1'b1;
    end

    if (in_xfer) begin
      idx_d = smp_last ? '0 : idx_q + IDX_W'(1);
    end

    if (in_xfer && sat_now) begin
      sat_d = 1'b1;
    end else if (sat_clr) begin
      sat_d = 1'b0;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      main_last_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_last_q  <= 1'b0;
      idx_q        <= '0;
      sat_q        <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      main_last_q  <= main_last_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_last_q  <= skid_last_d;
      idx_q        <= idx_d;
      sat_q        <= sat_d;
    end
  end

  assign m_axis_tvalid = main_valid_q;
  assign m_axis_tdata  = main_data_q;
  assign m_axis_tlast  = main_last_q;
  assign sat_sticky    = sat_q;

endmodule

// File: tb/tb_waverforms_out_stage.sv
// Directed bench for waverforms_out_stage: rounding, saturation, backpressure, framing, reset.
module tb_waverforms_out_stage;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic [29:0] prod_data;
  logic        prod_valid;
  logic        prod_ready;
  logic [15:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        sat_sticky;
  logic        sat_clr;

  int n_cmp = 0;
  int n_err = 0;

  waverforms_out_stage #(
    .IN_W(30), .OUT_W(16), .SHIFT(14), .FRAME_LEN(256)
  ) dut (
    .ap_clk        (ap_clk),
    .ap_rst_n      (ap_rst_n),
    .prod_data     (prod_data),
    .prod_valid    (prod_valid),
    .prod_ready    (prod_ready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .sat_sticky    (sat_sticky),
    .sat_clr       (sat_clr)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_tvalid"}, 32'(m_axis_tvalid), 32'd0);
    chk({tag, "_tdata"},  32'(m_axis_tdata),  32'd0);
    chk({tag, "_tlast"},  32'(m_axis_tlast),  32'd0);
    chk({tag, "_sat"},    32'(sat_sticky),    32'd0);
    chk({tag, "_ready"},  32'(prod_ready),    32'd1);
  endtask

  // Sample k is product k<<14, so it appears on tdata as k; tlast expected on every 256th output.
  task automatic stream(input int n, input bit rnd);
    int in_cnt  = 0;
    int out_cnt = 0;
    int cyc     = 0;
    bit hold    = 1'b0;
    logic [15:0] hd = '0;
    logic        hl = 1'b0;
    while (out_cnt < n && cyc < 20 * n + 50) begin
      @(negedge ap_clk);
      cyc++;
      if (hold) begin
        chk("hold_valid", 32'(m_axis_tvalid), 32'd1);
        chk("hold_data",  32'(m_axis_tdata),  32'(hd));
        chk("hold_last",  32'(m_axis_tlast),  32'(hl));
      end
      m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      prod_valid    = (in_cnt < n);
      prod_data     = 30'(in_cnt << 14);
      if (prod_valid && prod_ready) in_cnt++;
      if (m_axis_tvalid && m_axis_tready) begin
        chk("stream_data", 32'(m_axis_tdata), 32'(out_cnt & 16'hFFFF));
        chk("stream_last", 32'(m_axis_tlast), 32'((out_cnt % 256) == 255));
        out_cnt++;
      end
      hold = m_axis_tvalid && !m_axis_tready;
      hd   = m_axis_tdata;
      hl   = m_axis_tlast;
    end
    chk("stream_count", 32'(out_cnt), 32'(n));
    prod_valid    = 1'b0;
    m_axis_tready = 1'b1;
  endtask

  initial begin
    int acc;
    int d;
    ap_rst_n      = 1'b0;
    prod_data     = '0;
    prod_valid    = 1'b0;
    m_axis_tready = 1'b1;
    sat_clr       = 1'b0;
    repeat (2) @(negedge ap_clk);
    chk_reset_state("rst0");
    ap_rst_n = 1'b1;

    // Rounding
    @(negedge ap_clk); prod_valid = 1'b1; prod_data = 30'h1FFF;
    @(negedge ap_clk);
    chk("rnd0_valid", 32'(m_axis_tvalid), 32'd1);
    chk("rnd0_data",  32'(m_axis_tdata),  32'h0000);
    prod_data = 30'h2000;
    @(negedge ap_clk);
    chk("rnd1_data",  32'(m_axis_tdata),  32'h0001);
    prod_data = 30'h6000;
    @(negedge ap_clk);
    chk("rnd2_data",  32'(m_axis_tdata),  32'h0002);
    prod_valid = 1'b0;
    @(negedge ap_clk);
    chk("rnd_drain",  32'(m_axis_tvalid), 32'd0);
    chk("rnd_sat",    32'(sat_sticky),    32'd0);

    // Saturation: 0x3FFFDFFF rounds to exactly 0xFFFF, 0x3FFFE000 and above overflow
    prod_valid = 1'b1; prod_data = 30'h3FFFDFFF;
    @(negedge ap_clk);
    chk("satb_data", 32'(m_axis_tdata), 32'hFFFF);
    chk("satb_sat",  32'(sat_sticky),   32'd0);
    prod_data = 30'h3FFFFFFF;
    @(negedge ap_clk);
    chk("sat1_data", 32'(m_axis_tdata), 32'hFFFF);
    chk("sat1_sat",  32'(sat_sticky),   32'd1);
    prod_valid = 1'b0; sat_clr = 1'b1;
    @(negedge ap_clk);
    chk("satclr_sat", 32'(sat_sticky), 32'd0);
    prod_valid = 1'b1; prod_data = 30'h3FFFE000;
    @(negedge ap_clk);
    chk("satwin_sat",  32'(sat_sticky),   32'd1);
    chk("satwin_data", 32'(m_axis_tdata), 32'hFFFF);
    prod_valid = 1'b0; sat_clr = 1'b0;
    @(negedge ap_clk);
    chk("sathold_sat", 32'(sat_sticky),    32'd1);
    chk("sat_drain",   32'(m_axis_tvalid), 32'd0);

    // Backpressure
    acc = 0;
    d   = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge ap_clk);
      if (i > 0) begin
        chk("bp_valid", 32'(m_axis_tvalid), 32'd1);
        chk("bp_data",  32'(m_axis_tdata),  32'd1);
      end
      m_axis_tready = 1'b0;
      prod_valid    = 1'b1;
      prod_data     = 30'(d << 14);
      if (prod_ready) begin
        acc++;
        d++;
      end
    end
    @(negedge ap_clk);
    chk("bp_accepted", 32'(acc),          32'd2);
    chk("bp_ready",    32'(prod_ready),   32'd0);
    chk("bp_hold",     32'(m_axis_tdata), 32'd1);
    for (int j = 0; j < 8; j++) begin
      if (j > 0) @(negedge ap_clk);
      m_axis_tready = 1'b1;
      prod_valid    = (d <= 8);
      prod_data     = 30'(d << 14);
      if (prod_valid && prod_ready) d++;
      chk("bp_out_valid", 32'(m_axis_tvalid), 32'd1);
      chk("bp_out_data",  32'(m_axis_tdata),  32'(j + 1));
    end
    @(negedge ap_clk);
    prod_valid = 1'b0;
    chk("bp_drain", 32'(m_axis_tvalid), 32'd0);

    // Framing from a fresh index
    ap_rst_n = 1'b0;
    #2;
    chk("rst1_sat", 32'(sat_sticky), 32'd0);
    @(negedge ap_clk);
    chk_reset_state("rst1");
    ap_rst_n = 1'b1;
    stream(600, 1'b1);

    // Reset mid-frame with the skid full
    stream(100, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge ap_clk);
      m_axis_tready = 1'b0;
      prod_valid    = 1'b1;
      prod_data     = 30'h0004000;
    end
    @(negedge ap_clk);
    chk("mid_ready_pre", 32'(prod_ready),    32'd0);
    chk("mid_valid_pre", 32'(m_axis_tvalid), 32'd1);
    #2;
    ap_rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(m_axis_tvalid), 32'd0);
    chk("mid_rst_ready", 32'(prod_ready),    32'd1);
    chk("mid_rst_last",  32'(m_axis_tlast),  32'd0);
    prod_valid    = 1'b0;
    m_axis_tready = 1'b1;
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    stream(300, 1'b0);
    @(negedge ap_clk);
    chk("final_drain", 32'(m_axis_tvalid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
